// File: rtl/alu_iterative.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Logic, arithmetic and compare ops complete in one cycle; shifts run on a
// 1-bit-per-cycle iterative shifter, so their latency follows the shift amount.
module alu_iterative #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic [DATA_WIDTH-1:0] r_work;
    logic [SHAMT_W-1:0]    r_cnt;
    logic [3:0]            r_op;

    logic                  w_in_xfer;
    logic                  w_is_shift;
    logic [SHAMT_W-1:0]    w_shamt;
    logic                  w_start_shift;
    logic                  w_last_shift;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_in_xfer     = InValid && InReady;
    assign w_is_shift    = (Operation == OP_SRL) || (Operation == OP_SLL) || (Operation == OP_SRA);
    assign w_shamt       = SrcB[SHAMT_W-1:0];
    assign w_start_shift = w_in_xfer && w_is_shift && (w_shamt != '0);
    assign w_last_shift  = (r_state == ST_SHIFT) && (r_cnt == SHAMT_W'(1));

    // Single-cycle result; shift codes pass SrcA through (only used when shamt is 0)
    always_comb begin
        w_alu = '0;
        case (Operation)
            OP_AND:                 w_alu = SrcA & SrcB;
            OP_OR:                  w_alu = SrcA | SrcB;
            OP_ADD:                 w_alu = SrcA + SrcB;
            OP_SUB:                 w_alu = SrcA - SrcB;
            OP_XOR:                 w_alu = SrcA ^ SrcB;
            OP_SRL, OP_SLL, OP_SRA: w_alu = SrcA;
            OP_EQ:                  w_alu = DATA_WIDTH'(SrcA == SrcB);
            OP_SLT:                 w_alu = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            default:                w_alu = '0;
        endcase
    end

    // One-bit step of the iterative shifter for the captured shift op
    always_comb begin
        w_shift_next = r_work;
        case (r_op)
            OP_SRL:  w_shift_next = {1'b0, r_work[DATA_WIDTH-1:1]};
            OP_SLL:  w_shift_next = {r_work[DATA_WIDTH-2:0], 1'b0};
            default: w_shift_next = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a DONE-state input transfer behaves like the IDLE accept
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_in_xfer) begin
                    w_next_state = w_start_shift ? ST_SHIFT : ST_DONE;
                end else if ((r_state == ST_DONE) && OutReady) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs; InReady is combinational so a DONE result can be replaced back-to-back
    always_comb begin
        InReady   = reset && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && OutReady));
        OutValid  = (r_state == ST_DONE);
        ALUResult = r_result;
        Zero      = r_zero;
    end

    // Result, zero flag and shifter datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_work   <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
        end else begin
            if (w_in_xfer && !w_start_shift) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end else if (w_last_shift) begin
                r_result <= w_shift_next;
                r_zero   <= (w_shift_next == '0);
            end

            if (w_start_shift) begin
                r_work <= SrcA;
                r_cnt  <= w_shamt;
                r_op   <= Operation;
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_shift_next;
                r_cnt  <= r_cnt - SHAMT_W'(1);
            end
        end
    end

endmodule
